// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package hazard_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero is never a real producer, so a lw targeting it cannot create a hazard.
  function automatic logic load_use_hit(
    input logic       ex_memread,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_memread && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_timer.sv
// Counts consecutive un-acked memory cycles; expired_o fires on the cycle that
// would bring the count to MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)    cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = inc_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencing controller: memory stalls, load-use bubbles, ID
// flushes, run gating and memory timeout. HAZARD_CTRL_PERF_EN adds perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             id_branch_taken_i,
  input  logic             id_jump_i,
  input  logic             mem_access_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_hold_o,
  output logic             mem_req_o,
  output logic             timeout_o,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_e state_q;
  logic   timeout_q;
  logic   active;
  logic   mem_stall;
  logic   load_use;
  logic   expired;

  assign active    = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
  assign mem_stall = active && mem_access_i && !mem_ack_i;
  assign load_use  = load_use_hit(ex_memread_i, ex_rt_i, id_rs_i, id_rt_i, id_uses_rt_i);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (!mem_stall),
    .inc_i     (mem_stall),
    .expired_o (expired)
  );

  // Mealy outputs; priority is memory stall, then load-use, then flush.
  always_comb begin
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    pipe_hold_o    = 1'b1;
    mem_req_o      = 1'b0;
    if (active) begin
      mem_req_o   = mem_access_i;
      pipe_hold_o = 1'b0;
      if (mem_stall) begin
        pipe_hold_o = 1'b1;
      end else if (load_use) begin
        id_ex_bubble_o = 1'b1;
      end else begin
        pc_write_o    = 1'b1;
        if_id_write_o = 1'b1;
        if_id_flush_o = id_branch_taken_i | id_jump_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) state_q <= ST_RUN;
        ST_RUN, ST_MEM_WAIT: begin
          if (expired) begin
            state_q   <= ST_FAULT;
            timeout_q <= 1'b1;
          end else if (mem_stall) begin
            state_q <= ST_MEM_WAIT;
          end else if (!start_i) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_FAULT: state_q <= ST_FAULT;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o   = state_q;
  assign timeout_o = timeout_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters so long runs never wrap to a misleading small value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (active && !pc_write_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (if_id_flush_o && (flush_cnt_q != '1))         flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for single-cycle hazard decisions
// plus hand-written multi-cycle sequences (memory wait, timeout, reset, start).
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  logic clk_i = 1'b0;
  logic rst_i, start_i;
  logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
  logic id_uses_rt_i, ex_memread_i, id_branch_taken_i, id_jump_i;
  logic mem_access_i, mem_ack_i;
  logic pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o;
  logic pipe_hold_o, mem_req_o, timeout_o;
  logic [1:0] state_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
    .id_branch_taken_i(id_branch_taken_i), .id_jump_i(id_jump_i),
    .mem_access_i(mem_access_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_bubble_o(id_ex_bubble_o),
    .pipe_hold_o(pipe_hold_o), .mem_req_o(mem_req_o), .timeout_o(timeout_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Observed bundle: {pc, ifw, flush, bubble, hold, req, timeout, state[1:0]}
  logic [8:0] obs;
  assign obs = {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
                pipe_hold_o, mem_req_o, timeout_o, state_o};

  localparam logic [8:0] O_IDLE   = 9'b000010000;
  localparam logic [8:0] O_RUN    = 9'b110000001;
  localparam logic [8:0] O_FLUSH  = 9'b111000001;
  localparam logic [8:0] O_LU     = 9'b000100001;
  localparam logic [8:0] O_HOLD_R = 9'b000011001;
  localparam logic [8:0] O_HOLD_W = 9'b000011010;
  localparam logic [8:0] O_ACK_W  = 9'b110001010;
  localparam logic [8:0] O_LU_ACK = 9'b000101010;
  localparam logic [8:0] O_FAULT  = 9'b000010111;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare against the oldest expected value, then advance to the next negedge.
  task automatic run_cycle(input string name);
    logic [8:0] e;
    e = exp_q.pop_front();
    #1 check(name, 32'(obs), 32'(e));
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    id_rs_i = 5'd0; id_rt_i = 5'd0; id_uses_rt_i = 1'b0;
    ex_memread_i = 1'b0; ex_rt_i = 5'd0;
    id_branch_taken_i = 1'b0; id_jump_i = 1'b0;
    mem_access_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  // Reset then start: returns at a negedge with the DUT in RUN.
  task automatic restart();
    rst_i = 1'b1; start_i = 1'b0; clear_inputs();
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic check_cnt(input string name, input logic [31:0] exp_stall, input logic [31:0] exp_flush);
`ifdef HAZARD_CTRL_PERF_EN
    check({name, "_stall_cnt"}, stall_cnt_o, exp_stall);
    check({name, "_flush_cnt"}, flush_cnt_o, exp_flush);
`else
    check({name, "_stall_cnt"}, stall_cnt_o, 32'd0 & exp_stall);
    check({name, "_flush_cnt"}, flush_cnt_o, 32'd0 & exp_flush);
`endif
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, memread;
    logic [4:0] ex_rt;
    logic       br, j, acc, ack;
    logic [8:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                              input logic memread, input logic [4:0] ex_rt, input logic br,
                              input logic j, input logic acc, input logic ack, input logic [8:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.memread = memread; v.ex_rt = ex_rt;
    v.br = br; v.j = j; v.acc = acc; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    vecs[0] = mk(5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 0, O_RUN);        // plain
    vecs[1] = mk(5'd2, 5'd4, 1, 1, 5'd2, 0, 0, 0, 0, O_LU);         // rs hazard
    vecs[2] = mk(5'd3, 5'd2, 1, 1, 5'd2, 0, 0, 0, 0, O_LU);         // rt hazard
    vecs[3] = mk(5'd3, 5'd2, 0, 1, 5'd2, 0, 0, 0, 0, O_RUN);        // rt not read
    vecs[4] = mk(5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0, O_RUN);        // lw to $zero
    vecs[5] = mk(5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 0, 0, O_FLUSH);      // beq taken
    vecs[6] = mk(5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0, 0, O_FLUSH);      // jump
    vecs[7] = mk(5'd2, 5'd4, 1, 1, 5'd2, 1, 0, 0, 0, O_LU);         // load-use beats flush
    vecs[8] = mk(5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 1, 9'b110001001); // zero-wait access
    vecs[9] = mk(5'd2, 5'd4, 1, 1, 5'd2, 0, 0, 1, 1, 9'b000101001); // zero-wait + load-use

    rst_i = 1'b1; start_i = 1'b0; clear_inputs();

    // Reset and idle gating
    repeat (2) @(negedge clk_i);
    #1 check("reset_out", 32'(obs), 32'(O_IDLE));
    check_cnt("reset", 32'd0, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(O_IDLE);
      run_cycle($sformatf("idle_%0d", i));
    end
    start_i = 1'b1;
    exp_q.push_back(O_IDLE); run_cycle("start_edge");
    exp_q.push_back(O_RUN);  run_cycle("start_run");

    // Single-cycle hazard decisions in RUN
    for (int i = 0; i < 10; i++) begin
      id_rs_i = vecs[i].rs; id_rt_i = vecs[i].rt; id_uses_rt_i = vecs[i].uses_rt;
      ex_memread_i = vecs[i].memread; ex_rt_i = vecs[i].ex_rt;
      id_branch_taken_i = vecs[i].br; id_jump_i = vecs[i].j;
      mem_access_i = vecs[i].acc; mem_ack_i = vecs[i].ack;
      exp_q.push_back(vecs[i].exp);
      run_cycle($sformatf("vec_%0d", i));
    end

    // One flush counted
    restart();
    id_branch_taken_i = 1'b1;
    exp_q.push_back(O_FLUSH); run_cycle("flush_cycle");
    id_branch_taken_i = 1'b0;
    exp_q.push_back(O_RUN);   run_cycle("flush_after");
    check_cnt("flush", 32'd0, 32'd1);

    // Memory wait, ack on the 4th cycle (the one that would hit MEM_TIMEOUT)
    restart();
    mem_access_i = 1'b1; mem_ack_i = 1'b0;
    exp_q.push_back(O_HOLD_R); run_cycle("mw_hold1");
    exp_q.push_back(O_HOLD_W); run_cycle("mw_hold2");
    exp_q.push_back(O_HOLD_W); run_cycle("mw_hold3");
    mem_ack_i = 1'b1;
    exp_q.push_back(O_ACK_W);  run_cycle("mw_ack");
    mem_access_i = 1'b0; mem_ack_i = 1'b0;
    exp_q.push_back(O_RUN);    run_cycle("mw_release");
    check_cnt("mw", 32'd3, 32'd0);

    // Load-use masked by memory stall, then bubble on ack
    restart();
    id_rs_i = 5'd2; id_uses_rt_i = 1'b1; ex_memread_i = 1'b1; ex_rt_i = 5'd2;
    mem_access_i = 1'b1; mem_ack_i = 1'b0;
    exp_q.push_back(O_HOLD_R); run_cycle("lu_mem_hold1");
    exp_q.push_back(O_HOLD_W); run_cycle("lu_mem_hold2");
    mem_ack_i = 1'b1;
    exp_q.push_back(O_LU_ACK); run_cycle("lu_mem_ack");
    clear_inputs();
    exp_q.push_back(O_RUN);    run_cycle("lu_mem_after");
    check_cnt("lu_mem", 32'd3, 32'd0);

    // start_i drop in RUN and in MEM_WAIT
    restart();
    start_i = 1'b0;
    exp_q.push_back(O_RUN);  run_cycle("stop_run");
    exp_q.push_back(O_IDLE); run_cycle("stop_idle");
    restart();
    mem_access_i = 1'b1;
    exp_q.push_back(O_HOLD_R); run_cycle("stop_mw_hold1");
    start_i = 1'b0;
    exp_q.push_back(O_HOLD_W); run_cycle("stop_mw_hold2");
    mem_ack_i = 1'b1;
    exp_q.push_back(O_ACK_W);  run_cycle("stop_mw_ack");
    exp_q.push_back(O_IDLE);   run_cycle("stop_mw_idle");

    // Timeout after MEM_TIMEOUT un-acked cycles, sticky until reset
    restart();
    mem_access_i = 1'b1; mem_ack_i = 1'b0;
    exp_q.push_back(O_HOLD_R); run_cycle("to_hold1");
    for (int i = 2; i <= 4; i++) begin
      exp_q.push_back(O_HOLD_W); run_cycle($sformatf("to_hold%0d", i));
    end
    exp_q.push_back(O_FAULT); run_cycle("to_fault");
    check_cnt("to", 32'd4, 32'd0);
    mem_ack_i = 1'b1;
    exp_q.push_back(O_FAULT); run_cycle("to_sticky_ack");
    start_i = 1'b0;
    exp_q.push_back(O_FAULT); run_cycle("to_sticky_stop");
    rst_i = 1'b1;
    @(negedge clk_i);
    exp_q.push_back(O_IDLE);  run_cycle("to_reset");

    // Reset in the middle of MEM_WAIT forgets the access
    restart();
    mem_access_i = 1'b1;
    exp_q.push_back(O_HOLD_R); run_cycle("rmw_hold1");
    exp_q.push_back(O_HOLD_W); run_cycle("rmw_hold2");
    rst_i = 1'b1;
    @(negedge clk_i);
    exp_q.push_back(O_IDLE);   run_cycle("rmw_reset");
    check_cnt("rmw", 32'd0, 32'd0);
    rst_i = 1'b0; start_i = 1'b1; mem_access_i = 1'b0;
    @(negedge clk_i);
    exp_q.push_back(O_RUN);    run_cycle("rmw_resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Each cycle it decides PC, IF/ID and ID/EX write enables, flushes and bubbles from load-use hazards, taken branches and jumps resolved in ID, and variable-latency data-memory handshakes. It also gates the whole pipeline on start_i and flags hung memory accesses.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive un-acked memory cycles before fault; legal range 2..255.
- CNT_W, 32: performance counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  run enable (level)
- id_rs_i  in  5  rs field of instruction in IF/ID
- id_rt_i  in  5  rt field of instruction in IF/ID
- id_uses_rt_i  in  1  IF/ID instruction reads rt (R-type, beq, sw)
- ex_memread_i  in  1  ID/EX holds a lw
- ex_rt_i  in  5  destination of the lw in ID/EX
- id_branch_taken_i  in  1  beq in ID with equal operands
- id_jump_i  in  1  j in ID
- mem_access_i  in  1  EX/MEM holds lw or sw
- mem_ack_i  in  1  data memory completes current access
- pc_write_o  out  1  PC load enable
- if_id_write_o  out  1  IF/ID load enable
- if_id_flush_o  out  1  load NOP into IF/ID
- id_ex_bubble_o  out  1  zero ID/EX control fields
- pipe_hold_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
- mem_req_o  out  1  data memory request
- timeout_o  out  1  sticky memory timeout
- state_o  out  2  current FSM state
- stall_cnt_o  out  CNT_W  stall cycles (see Configuration)
- flush_cnt_o  out  CNT_W  flushes (see Configuration)

## Operation
- States: IDLE=0, RUN=1, MEM_WAIT=2, FAULT=3. Reset -> IDLE.
- IDLE/FAULT outputs: pc_write_o=0, if_id_write_o=0, pipe_hold_o=1, flush/bubble/mem_req_o=0.
- IDLE -> RUN when start_i=1. FAULT exits only on rst_i.
- Memory stall (RUN or MEM_WAIT, mem_access_i=1, mem_ack_i=0): mem_req_o=1, pipe_hold_o=1, pc_write_o=0, if_id_write_o=0, flush=0, bubble=0. RUN -> MEM_WAIT.
- mem_req_o = mem_access_i in RUN/MEM_WAIT. Ack cycle: hold released, hazard logic below applies, MEM_WAIT -> RUN.
- Load-use (no memory stall): ex_memread_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_uses_rt_i && ex_rt_i==id_rt_i)) -> pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, flush=0.
- Control flow (no stall of either kind): id_branch_taken_i|id_jump_i -> if_id_flush_o=1, pc_write_o=1.
- Otherwise pc_write_o=if_id_write_o=1, others 0.
- Priority: memory stall > load-use > flush.
- start_i=0 in RUN -> IDLE next cycle unless a memory stall is active. In MEM_WAIT the access completes first, then -> IDLE.
- Wait counter counts consecutive un-acked access cycles, including the RUN entry cycle, and clears on ack. At count==MEM_TIMEOUT -> FAULT, timeout_o=1.

## Timing
- All control outputs are combinational from state and inputs (Mealy) and take effect in the same cycle. State and counters are registered.
- Zero-wait access (ack with request) causes no stall and no MEM_WAIT entry.
- Ack in the cycle the counter would reach MEM_TIMEOUT: ack wins, no fault.
- rst_i mid-MEM_WAIT -> IDLE next edge; counters and timeout_o cleared; no pending access is remembered.
- Reset values: state_o=0, timeout_o=0, counters 0, outputs per IDLE.

## Configuration
- HAZARD_CTRL_PERF_EN defined:
  - stall_cnt_o increments on each RUN/MEM_WAIT cycle with pc_write_o=0.
  - flush_cnt_o increments on each if_id_flush_o=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports tied to 0; no counter flops.

## Structure
- Package hazard_ctrl_pkg:
  - state encodings and STATE_W=2
  - REG_ZERO=5'd0
- Sub-module mem_wait_timer: clear/increment/expired counter, width $clog2(MEM_TIMEOUT+1).

## Test plan
- Reset, start_i=0 for 3 cycles -> state_o=0, pc_write_o=0, pipe_hold_o=1. start_i=1 -> state_o=1 next cycle.
- lw $2 in ID/EX, add $3,$2,$4 in ID -> one cycle with pc_write_o=0, id_ex_bubble_o=1. Same with ex_rt_i=0 -> no stall.
- beq taken in ID, no hazard -> if_id_flush_o=1, pc_write_o=1 for one cycle; flush_cnt_o=1 with macro.
- mem_access_i=1, ack after 3 cycles -> pipe_hold_o=1 for 3 cycles, state_o=2, released on ack; stall_cnt_o=3.
- MEM_TIMEOUT=4, no ack -> state_o=3 and timeout_o=1 after 4 hold cycles; persists until rst_i.
- Load-use plus memory stall together -> bubble=0 while held. After ack, load-use bubble for one cycle.
